// File: rtl/uart_pkg.sv
// Shared constants and types for the 6502-side UART bus controller.
package uart_pkg;
  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;
  localparam logic [1:0] REG_CMD    = 2'd3;

  localparam int ST_RX_AVAIL = 0;
  localparam int ST_TX_SPACE = 1;
  localparam int ST_RX_OVR   = 2;
  localparam int ST_TX_IDLE  = 3;
  localparam int ST_TX_OVR   = 4;
  localparam int ST_IRQ      = 7;

  localparam int CTRL_RX_IE = 0;
  localparam int CTRL_TX_IE = 1;

  localparam int CMD_TX_FLUSH = 0;
  localparam int CMD_RX_FLUSH = 1;
  localparam int CMD_CLR_OVR  = 2;

  typedef enum logic [1:0] {IDLE, LOAD, KICK, BUSY} tx_state_t;
endpackage

// File: rtl/uart_bus_ctrl_if.sv
// CPU bus and UART handshake signals seen by the bus controller.
interface uart_bus_ctrl_if;
  logic       cs;
  logic       rw;
  logic [1:0] addr;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic       irq_n;
  logic       uart_tx_write;
  logic [7:0] uart_tx_data;
  logic       uart_tx_finished;
  logic       uart_rx_ready;
  logic [7:0] uart_rx_data;

  modport slave (
    input  cs, rw, addr, data_in, uart_tx_finished, uart_rx_ready, uart_rx_data,
    output data_out, irq_n, uart_tx_write, uart_tx_data
  );
  modport master (
    output cs, rw, addr, data_in, uart_tx_finished, uart_rx_ready, uart_rx_data,
    input  data_out, irq_n, uart_tx_write, uart_tx_data
  );
endinterface

// File: rtl/sync_fifo.sv
// Falling-edge synchronous FIFO; push while full is accepted only alongside a pop.
module sync_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             n_reset,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head,
  output logic [AW:0]      count
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr, wr_ptr;
  logic             do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign head    = mem[rd_ptr];

  // Flush beats any coincident push or pop.
  always_ff @(negedge clk) begin
    if (!n_reset || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(negedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end
endmodule

// File: rtl/uart_bus_ctrl.sv
// Memory-mapped UART controller: register decode, TX sequencing FSM, sticky flags, IRQ.
module uart_bus_ctrl
  import uart_pkg::*;
#(
  parameter int TX_DEPTH = 8,
  parameter int RX_DEPTH = 8
) (
  input logic            clk,
  input logic            n_reset,
  uart_bus_ctrl_if.slave bus
);
  localparam int TAW = $clog2(TX_DEPTH);
  localparam int RAW = $clog2(RX_DEPTH);

  tx_state_t    state, state_nxt;
  logic         cpu_wr, cpu_rd, cmd_wr, ctrl_wr;
  logic         tx_push, tx_pop, tx_flush, tx_full, tx_empty;
  logic         rx_pop, rx_flush, rx_full, rx_empty, rx_pop_eff;
  logic [7:0]   tx_head, rx_head, tx_hold, rd_mux;
  logic [TAW:0] tx_count;
  logic [RAW:0] rx_count;
  logic         tx_drop, rx_drop, ovr_clr;
  logic         rx_ovr, tx_ovr, rx_ie, tx_ie;
  logic         rx_avail, tx_space, tx_idle, irq;

  assign cpu_wr  = bus.cs & ~bus.rw;
  assign cpu_rd  = bus.cs &  bus.rw;
  assign cmd_wr  = cpu_wr & (bus.addr == REG_CMD);
  assign ctrl_wr = cpu_wr & (bus.addr == REG_CTRL);

  assign tx_push  = cpu_wr & (bus.addr == REG_DATA);
  assign tx_flush = cmd_wr & bus.data_in[CMD_TX_FLUSH];
  assign rx_flush = cmd_wr & bus.data_in[CMD_RX_FLUSH];
  assign ovr_clr  = cmd_wr & bus.data_in[CMD_CLR_OVR];
  assign rx_pop   = cpu_rd & (bus.addr == REG_DATA);

  // A full FIFO still takes a byte when the head leaves in the same cycle.
  assign rx_pop_eff = rx_pop & ~rx_empty;
  assign tx_drop    = tx_push & tx_full & ~tx_pop;
  assign rx_drop    = bus.uart_rx_ready & rx_full & ~rx_pop_eff;

  sync_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk(clk), .n_reset(n_reset), .push(tx_push), .pop(tx_pop), .flush(tx_flush),
    .din(bus.data_in), .full(tx_full), .empty(tx_empty), .head(tx_head), .count(tx_count)
  );

  sync_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk(clk), .n_reset(n_reset), .push(bus.uart_rx_ready), .pop(rx_pop), .flush(rx_flush),
    .din(bus.uart_rx_data), .full(rx_full), .empty(rx_empty), .head(rx_head), .count(rx_count)
  );

  always_ff @(negedge clk) begin
    if (!n_reset) state <= IDLE;
    else          state <= state_nxt;
  end

  // The head is popped on the way into LOAD so tx_data is stable for the whole frame.
  always_comb begin
    state_nxt = state;
    tx_pop    = 1'b0;
    unique case (state)
      IDLE: if (!tx_empty && !tx_flush) begin
        state_nxt = LOAD;
        tx_pop    = 1'b1;
      end
      LOAD:    state_nxt = KICK;
      KICK:    state_nxt = BUSY;
      BUSY:    if (bus.uart_tx_finished) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(negedge clk) begin
    if (!n_reset) begin
      tx_hold <= 8'h00;
      rx_ovr  <= 1'b0;
      tx_ovr  <= 1'b0;
      rx_ie   <= 1'b0;
      tx_ie   <= 1'b0;
    end else begin
      if (tx_pop) tx_hold <= tx_head;
      if (rx_drop)      rx_ovr <= 1'b1;
      else if (ovr_clr) rx_ovr <= 1'b0;
      if (tx_drop)      tx_ovr <= 1'b1;
      else if (ovr_clr) tx_ovr <= 1'b0;
      if (ctrl_wr) begin
        rx_ie <= bus.data_in[CTRL_RX_IE];
        tx_ie <= bus.data_in[CTRL_TX_IE];
      end
    end
  end

  assign rx_avail = (rx_count != '0);
  assign tx_space = (tx_count != (TAW+1)'(TX_DEPTH));
  assign tx_idle  = (state == IDLE) & tx_empty;
  assign irq      = (rx_ie & rx_avail) | (tx_ie & tx_idle);

  always_comb begin
    rd_mux = 8'h00;
    case (bus.addr)
      REG_DATA:   rd_mux = rx_empty ? 8'h00 : rx_head;
      REG_STATUS: begin
        rd_mux[ST_RX_AVAIL] = rx_avail;
        rd_mux[ST_TX_SPACE] = tx_space;
        rd_mux[ST_RX_OVR]   = rx_ovr;
        rd_mux[ST_TX_IDLE]  = tx_idle;
        rd_mux[ST_TX_OVR]   = tx_ovr;
        rd_mux[ST_IRQ]      = irq;
      end
      REG_CTRL: begin
        rd_mux[CTRL_RX_IE] = rx_ie;
        rd_mux[CTRL_TX_IE] = tx_ie;
      end
      default: rd_mux = 8'h00;
    endcase
  end

  assign bus.data_out      = rd_mux;
  assign bus.irq_n         = ~irq;
  assign bus.uart_tx_write = (state == KICK);
  assign bus.uart_tx_data  = tx_hold;
endmodule
